// File: rtl/i2c_target.sv
// i2c_target: I2C target (slave) endpoint at a fixed 7-bit address.
//
// An external I2C controller writes bytes into the SoC and reads bytes back.
// SCL/SDA are oversampled on clk, which must run at least 16x the SCL rate.
// Received bytes leave on rx_data/rx_valid. Transmit bytes are pulled from
// tx_data/tx_valid with a tx_ready pulse.
//
// Configuration macro: I2C_TARGET_STRETCH_EN
//   defined   - when a read byte is needed and tx_valid is low, SCL is held
//               low (clock stretch) until tx_valid rises.
//   undefined - 8'hFF is sent instead and tx_underrun pulses; scl_oe stays 0.
//
// Ports:
//   clk          core clock
//   reset_n      asynchronous active-low reset
//   scl_in       SCL pad input (asynchronous)
//   sda_in       SDA pad input (asynchronous)
//   scl_oe       1 = pull SCL low (stretch)
//   sda_oe       1 = pull SDA low
//   rx_data      last byte written by the controller
//   rx_valid     one-cycle pulse when rx_data updates
//   rx_first     qualifies rx_valid: first data byte after the address
//   tx_data      byte to return on controller reads
//   tx_valid     tx_data holds an unconsumed byte (level)
//   tx_ready     one-cycle pulse when tx_data is consumed
//   tx_underrun  one-cycle pulse when a byte was needed but tx_valid was low
//   busy         high from own-address ACK until STOP, START or NACKed read
module i2c_target #(
   parameter logic [6:0] ADDR = 7'h50
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       scl_oe,
   output logic       sda_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_first,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_underrun,
   output logic       busy
);

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_ADDR     = 4'd1,
      ST_ADDR_ACK = 4'd2,
      ST_WR_DATA  = 4'd3,
      ST_WR_ACK   = 4'd4,
      ST_RD_DATA  = 4'd5,
      ST_RD_ACK   = 4'd6,
      ST_IGNORE   = 4'd7
`ifdef I2C_TARGET_STRETCH_EN
      , ST_STRETCH = 4'd8
`endif
   } state_t;

   // Input synchronizers plus delay stage for edge detection
   logic       scl_meta_r, scl_sync_r, scl_dly_r;
   logic       sda_meta_r, sda_sync_r, sda_dly_r;
   logic [1:0] warm_r;

   logic ev_en_s, scl_rise_s, scl_fall_s, start_s, stop_s;

   state_t     state_r, state_nxt;
   // Only bits 6..0 are stored: the newest bit is taken straight from SDA on
   // receive, and bit 7 is driven straight from tx_data on a fetch.
   logic [6:0] sr_r, sr_nxt;
   logic [7:0] sr_shift_s;
   logic [3:0] cnt_r, cnt_nxt;
   logic       rw_r, rw_nxt;
   logic       match_r, match_nxt;
   logic       first_r, first_nxt;
   logic       acked_r, acked_nxt;
   logic       fetch_s;

   logic       scl_oe_r, scl_oe_nxt;
   logic       sda_oe_r, sda_oe_nxt;
   logic [7:0] rx_data_r, rx_data_nxt;
   logic       rx_valid_r, rx_valid_nxt;
   logic       rx_first_r, rx_first_nxt;
   logic       tx_ready_r, tx_ready_nxt;
   logic       tx_underrun_r, tx_underrun_nxt;
   logic       busy_r, busy_nxt;

   // Two-flop synchronizers, delay register and post-reset warm-up counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         scl_meta_r <= 1'b1;
         scl_sync_r <= 1'b1;
         scl_dly_r  <= 1'b1;
         sda_meta_r <= 1'b1;
         sda_sync_r <= 1'b1;
         sda_dly_r  <= 1'b1;
         warm_r     <= 2'd0;
      end else begin
         scl_meta_r <= scl_in;
         scl_sync_r <= scl_meta_r;
         scl_dly_r  <= scl_sync_r;
         sda_meta_r <= sda_in;
         sda_sync_r <= sda_meta_r;
         sda_dly_r  <= sda_sync_r;
         if (warm_r != 2'd3) begin
            warm_r <= warm_r + 2'd1;
         end
      end
   end

   // Events are masked until the synchronizer pipeline has refilled after
   // reset, so lines sitting low at reset release cannot fake a START.
   assign ev_en_s    = (warm_r == 2'd3);
   assign scl_rise_s = ev_en_s &  scl_sync_r & ~scl_dly_r;
   assign scl_fall_s = ev_en_s & ~scl_sync_r &  scl_dly_r;
   assign start_s    = ev_en_s &  scl_sync_r &  scl_dly_r &  sda_dly_r & ~sda_sync_r;
   assign stop_s     = ev_en_s &  scl_sync_r &  scl_dly_r & ~sda_dly_r &  sda_sync_r;
   assign sr_shift_s = {sr_r, sda_sync_r};

   // Next-state, datapath and output decode
   always_comb begin
      state_nxt       = state_r;
      sr_nxt          = sr_r;
      cnt_nxt         = cnt_r;
      rw_nxt          = rw_r;
      match_nxt       = match_r;
      first_nxt       = first_r;
      acked_nxt       = acked_r;
      fetch_s         = 1'b0;
      scl_oe_nxt      = 1'b0;
      sda_oe_nxt      = sda_oe_r;
      rx_data_nxt     = rx_data_r;
      rx_valid_nxt    = 1'b0;
      rx_first_nxt    = 1'b0;
      tx_ready_nxt    = 1'b0;
      tx_underrun_nxt = 1'b0;
      busy_nxt        = busy_r;

      // Bus conditions take priority over any SCL edge in the same cycle.
      if (stop_s) begin
         state_nxt  = ST_IDLE;
         sda_oe_nxt = 1'b0;
         busy_nxt   = 1'b0;
      end else if (start_s) begin
         state_nxt  = ST_ADDR;
         cnt_nxt    = 4'd0;
         sda_oe_nxt = 1'b0;
         busy_nxt   = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               sda_oe_nxt = 1'b0;
               busy_nxt   = 1'b0;
            end
            ST_ADDR: begin
               if (scl_rise_s && (cnt_r < 4'd8)) begin
                  sr_nxt  = sr_shift_s[6:0];
                  cnt_nxt = cnt_r + 4'd1;
                  if (cnt_r == 4'd7) begin
                     match_nxt = (sr_shift_s[7:1] == ADDR);
                     rw_nxt    = sr_shift_s[0];
                  end else begin
                     match_nxt = match_r;
                  end
               end else if (scl_fall_s && (cnt_r == 4'd8)) begin
                  if (match_r) begin
                     sda_oe_nxt = 1'b1;
                     busy_nxt   = 1'b1;
                     state_nxt  = ST_ADDR_ACK;
                  end else begin
                     state_nxt  = ST_IGNORE;
                  end
               end else begin
                  state_nxt = ST_ADDR;
               end
            end
            ST_ADDR_ACK: begin
               if (scl_fall_s) begin
                  cnt_nxt = 4'd0;
                  if (!rw_r) begin
                     sda_oe_nxt = 1'b0;
                     first_nxt  = 1'b1;
                     state_nxt  = ST_WR_DATA;
                  end else begin
                     fetch_s = 1'b1;
                  end
               end else begin
                  state_nxt = ST_ADDR_ACK;
               end
            end
            ST_WR_DATA: begin
               if (scl_rise_s && (cnt_r < 4'd8)) begin
                  sr_nxt  = sr_shift_s[6:0];
                  cnt_nxt = cnt_r + 4'd1;
                  if (cnt_r == 4'd7) begin
                     rx_data_nxt  = sr_shift_s;
                     rx_valid_nxt = 1'b1;
                     rx_first_nxt = first_r;
                     first_nxt    = 1'b0;
                  end else begin
                     rx_valid_nxt = 1'b0;
                  end
               end else if (scl_fall_s && (cnt_r == 4'd8)) begin
                  sda_oe_nxt = 1'b1;
                  state_nxt  = ST_WR_ACK;
               end else begin
                  state_nxt = ST_WR_DATA;
               end
            end
            ST_WR_ACK: begin
               if (scl_fall_s) begin
                  sda_oe_nxt = 1'b0;
                  cnt_nxt    = 4'd0;
                  state_nxt  = ST_WR_DATA;
               end else begin
                  state_nxt = ST_WR_ACK;
               end
            end
            ST_RD_DATA: begin
               // cnt_r counts falls since bit 7 went out; sr_r[6] is next.
               if (scl_fall_s) begin
                  if (cnt_r < 4'd7) begin
                     cnt_nxt    = cnt_r + 4'd1;
                     sda_oe_nxt = ~sr_r[6];
                     sr_nxt     = {sr_r[5:0], 1'b1};
                  end else begin
                     sda_oe_nxt = 1'b0;
                     acked_nxt  = 1'b0;
                     state_nxt  = ST_RD_ACK;
                  end
               end else begin
                  state_nxt = ST_RD_DATA;
               end
            end
            ST_RD_ACK: begin
               if (scl_rise_s) begin
                  if (sda_sync_r) begin
                     busy_nxt  = 1'b0;
                     state_nxt = ST_IGNORE;
                  end else begin
                     acked_nxt = 1'b1;
                  end
               end else if (scl_fall_s && acked_r) begin
                  fetch_s = 1'b1;
               end else begin
                  state_nxt = ST_RD_ACK;
               end
            end
            ST_IGNORE: begin
               sda_oe_nxt = 1'b0;
               busy_nxt   = 1'b0;
            end
`ifdef I2C_TARGET_STRETCH_EN
            ST_STRETCH: begin
               // Stays asserted in the load cycle so SCL releases one clk later.
               scl_oe_nxt = 1'b1;
               if (tx_valid) begin
                  sr_nxt       = tx_data[6:0];
                  tx_ready_nxt = 1'b1;
                  sda_oe_nxt   = ~tx_data[7];
                  cnt_nxt      = 4'd0;
                  state_nxt    = ST_RD_DATA;
               end else begin
                  state_nxt = ST_STRETCH;
               end
            end
`endif
            default: begin
               state_nxt  = ST_IDLE;
               sda_oe_nxt = 1'b0;
               busy_nxt   = 1'b0;
            end
         endcase

         // Byte fetch for a read: load from tx_data, or handle the empty case.
         if (fetch_s) begin
            cnt_nxt = 4'd0;
            if (tx_valid) begin
               sr_nxt       = tx_data[6:0];
               tx_ready_nxt = 1'b1;
               sda_oe_nxt   = ~tx_data[7];
               state_nxt    = ST_RD_DATA;
            end else begin
`ifdef I2C_TARGET_STRETCH_EN
               scl_oe_nxt      = 1'b1;
               sda_oe_nxt      = 1'b0;
               state_nxt       = ST_STRETCH;
`else
               sr_nxt          = 7'h7F;
               tx_underrun_nxt = 1'b1;
               sda_oe_nxt      = 1'b0;
               state_nxt       = ST_RD_DATA;
`endif
            end
         end else begin
            cnt_nxt = cnt_nxt;
         end
      end
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r       <= ST_IDLE;
         sr_r          <= 7'h00;
         cnt_r         <= 4'd0;
         rw_r          <= 1'b0;
         match_r       <= 1'b0;
         first_r       <= 1'b0;
         acked_r       <= 1'b0;
         scl_oe_r      <= 1'b0;
         sda_oe_r      <= 1'b0;
         rx_data_r     <= 8'h00;
         rx_valid_r    <= 1'b0;
         rx_first_r    <= 1'b0;
         tx_ready_r    <= 1'b0;
         tx_underrun_r <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         state_r       <= state_nxt;
         sr_r          <= sr_nxt;
         cnt_r         <= cnt_nxt;
         rw_r          <= rw_nxt;
         match_r       <= match_nxt;
         first_r       <= first_nxt;
         acked_r       <= acked_nxt;
         scl_oe_r      <= scl_oe_nxt;
         sda_oe_r      <= sda_oe_nxt;
         rx_data_r     <= rx_data_nxt;
         rx_valid_r    <= rx_valid_nxt;
         rx_first_r    <= rx_first_nxt;
         tx_ready_r    <= tx_ready_nxt;
         tx_underrun_r <= tx_underrun_nxt;
         busy_r        <= busy_nxt;
      end
   end

   assign scl_oe      = scl_oe_r;
   assign sda_oe      = sda_oe_r;
   assign rx_data     = rx_data_r;
   assign rx_valid    = rx_valid_r;
   assign rx_first    = rx_first_r;
   assign tx_ready    = tx_ready_r;
   assign tx_underrun = tx_underrun_r;
   assign busy        = busy_r;

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bench for i2c_target. A behavioural I2C controller drives
// open-drain SCL/SDA; a transaction-level model predicts ACKs, received
// bytes, returned read bytes and strobe counts.
module tb_i2c_target;

   localparam int         Q        = 8;   // SCL-low time before release
   localparam int         H        = 10;  // SCL-high time
   localparam logic [6:0] OWN_ADDR = 7'h50;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       m_scl_low, m_sda_low;
   logic       scl_line, sda_line;
   logic       scl_oe, sda_oe;
   logic [7:0] rx_data;
   logic       rx_valid, rx_first;
   logic [7:0] tx_data  = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, tx_underrun, busy;

   always #5 clk = ~clk;

   assign scl_line = ~(m_scl_low | scl_oe);
   assign sda_line = ~(m_sda_low | sda_oe);

   i2c_target dut (
      .clk(clk), .reset_n(reset_n), .scl_in(scl_line), .sda_in(sda_line),
      .scl_oe(scl_oe), .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_first(rx_first), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .tx_underrun(tx_underrun), .busy(busy)
   );

   int checks   = 0;
   int failures = 0;

   // Transmit byte source: the stimulus writes tx_mem/tx_wr, the monitor pops.
   logic [7:0] tx_mem [64];
   int         tx_wr = 0;
   int         tx_rd = 0;

   // Monitor-owned observation counters and receive log
   logic [8:0] rx_q [$];
   int ready_cnt = 0, und_cnt = 0, scl_cnt = 0, sda_cnt = 0, busy_cnt = 0;
   logic [7:0] wr_bytes [4];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Monitor and tx source, evaluated away from the active edge
   always @(negedge clk) begin
      if (rx_valid) rx_q.push_back({rx_first, rx_data});
      if (tx_ready) begin
         ready_cnt++;
         if (tx_rd != tx_wr) tx_rd++;
      end
      if (tx_underrun) und_cnt++;
      if (scl_oe) scl_cnt++;
      if (sda_oe) sda_cnt++;
      if (busy) busy_cnt++;
      tx_valid = (tx_rd != tx_wr);
      tx_data  = tx_valid ? tx_mem[tx_rd % 64] : 8'h00;
   end

   initial begin
      repeat (60000) @(posedge clk);
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "bench timeout");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_scl_high();
      int n = 0;
      while (!scl_line && n < 1000) begin
         tick(1);
         n++;
      end
      check("scl_high", scl_line, 1'b1);
   endtask

   task automatic send_start();
      if (m_scl_low) begin
         m_sda_low = 1'b0;
         tick(Q);
         m_scl_low = 1'b0;
         wait_scl_high();
         tick(H);
      end
      m_sda_low = 1'b1;
      tick(H);
      m_scl_low = 1'b1;
      tick(Q);
   endtask

   task automatic send_stop();
      m_sda_low = 1'b1;
      tick(Q);
      m_scl_low = 1'b0;
      wait_scl_high();
      tick(H);
      m_sda_low = 1'b0;
      tick(H);
   endtask

   task automatic write_bit(input logic b);
      m_sda_low = ~b;
      tick(Q);
      m_scl_low = 1'b0;
      wait_scl_high();
      tick(H);
      m_scl_low = 1'b1;
      tick(3);
   endtask

   task automatic read_bit(output logic b);
      m_sda_low = 1'b0;
      tick(Q);
      m_scl_low = 1'b0;
      wait_scl_high();
      tick(H / 2);
      b = sda_line;
      tick(H / 2);
      m_scl_low = 1'b1;
      tick(3);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) write_bit(d[i]);
      read_bit(ack);
   endtask

   task automatic read_byte(output logic [7:0] d, input logic nack);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         d[i] = b;
      end
      write_bit(nack);
   endtask

   // Write transaction: model says ACK everything iff the address matches,
   // and every byte appears on rx with rx_first only on the first one.
   task automatic run_write(input logic [6:0] a, input int n, input logic do_stop);
      logic       ack, m;
      logic [8:0] e;
      int         rx_base, sda_base;
      m        = (a == OWN_ADDR);
      rx_base  = rx_q.size();
      sda_base = sda_cnt;
      send_start();
      write_byte({a, 1'b0}, ack);
      check("wr_addr_ack", ack, m ? 1'b0 : 1'b1);
      check("wr_busy_addr", busy, m);
      for (int i = 0; i < n; i++) begin
         write_byte(wr_bytes[i], ack);
         check("wr_data_ack", ack, m ? 1'b0 : 1'b1);
      end
      if (do_stop) begin
         send_stop();
         check("wr_busy_stop", busy, 1'b0);
      end
      check("rx_count", rx_q.size() - rx_base, m ? n : 0);
      if (m) begin
         for (int i = 0; i < n; i++) begin
            e = {(i == 0), wr_bytes[i]};
            if (rx_base + i < rx_q.size()) check("rx_byte", rx_q[rx_base + i], e);
         end
      end else begin
         check("wr_sda_quiet", sda_cnt - sda_base, 0);
      end
   endtask

   // Read transaction: n bytes are queued in advance and must come back in
   // order, one tx_ready each; the last byte is NACKed.
   task automatic run_read(input logic [6:0] a, input int n, input logic [7:0] first_byte);
      logic       ack, m;
      logic [7:0] exp [4];
      logic [7:0] got;
      int         rdy_base, und_base, sda_base;
      m        = (a == OWN_ADDR);
      rdy_base = ready_cnt;
      und_base = und_cnt;
      sda_base = sda_cnt;
      if (m) begin
         for (int i = 0; i < n; i++) begin
            exp[i] = (i == 0) ? first_byte : 8'($urandom);
            tx_mem[tx_wr % 64] = exp[i];
            tx_wr++;
         end
      end
      tick(2);
      send_start();
      write_byte({a, 1'b1}, ack);
      check("rd_addr_ack", ack, m ? 1'b0 : 1'b1);
      if (m) begin
         for (int i = 0; i < n; i++) begin
            read_byte(got, (i == n - 1));
            check("rd_byte", got, exp[i]);
         end
         check("rd_busy_nack", busy, 1'b0);
      end else begin
         check("rd_sda_quiet", sda_cnt - sda_base, 0);
      end
      send_stop();
      check("rd_ready_cnt", ready_cnt - rdy_base, m ? n : 0);
      check("rd_underrun", und_cnt - und_base, 0);
   endtask

   initial begin
      logic       ack;
      logic [7:0] b;
      int         rdy_base, und_base, scl_base, sda_base, busy_base, rx_base;

      reset_n   = 1'b0;
      m_scl_low = 1'b0;
      m_sda_low = 1'b0;
      tick(5);
      check("rst_scl_oe", scl_oe, 1'b0);
      check("rst_sda_oe", sda_oe, 1'b0);
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_rx_valid", rx_valid, 1'b0);
      check("rst_rx_first", rx_first, 1'b0);
      check("rst_tx_ready", tx_ready, 1'b0);
      check("rst_tx_underrun", tx_underrun, 1'b0);
      check("rst_busy", busy, 1'b0);
      reset_n = 1'b1;
      tick(5);

      // Two-byte write to own address
      wr_bytes[0] = 8'h5A;
      wr_bytes[1] = 8'hC3;
      run_write(7'h50, 2, 1'b1);

      // Neighbouring address is ignored
      wr_bytes[0] = 8'h12;
      run_write(7'h51, 1, 1'b1);

      // Single-byte read of 0xA5, NACKed
      run_read(7'h50, 1, 8'hA5);

      // Write then repeated START into a read
      wr_bytes[0] = 8'h11;
      run_write(7'h50, 1, 1'b0);
      run_read(7'h50, 2, 8'h96);

      // Read with no byte available for about 200 clk
      rdy_base = ready_cnt;
      und_base = und_cnt;
      scl_base = scl_cnt;
      send_start();
      write_byte(8'hA1, ack);
      check("empty_addr_ack", ack, 1'b0);
`ifdef I2C_TARGET_STRETCH_EN
      fork
         begin
            tick(200);
            tx_mem[tx_wr % 64] = 8'h3C;
            tx_wr++;
         end
      join_none
      read_byte(b, 1'b1);
      check("stretch_byte", b, 8'h3C);
      check("stretch_ready", ready_cnt - rdy_base, 1);
      check("stretch_underrun", und_cnt - und_base, 0);
      check("stretch_len_ok", ((scl_cnt - scl_base) >= 180) && ((scl_cnt - scl_base) <= 240), 1'b1);
`else
      read_byte(b, 1'b1);
      check("underrun_byte", b, 8'hFF);
      check("underrun_ready", ready_cnt - rdy_base, 0);
      check("underrun_pulses", und_cnt - und_base, 1);
      check("underrun_scl_oe", scl_cnt - scl_base, 0);
`endif
      send_stop();

      // Reset while driving a 0 read bit
      tx_mem[tx_wr % 64] = 8'h00;
      tx_wr++;
      tick(2);
      send_start();
      write_byte(8'hA1, ack);
      check("rst_rd_addr_ack", ack, 1'b0);
      tick(4);
      check("rst_rd_driving", sda_oe, 1'b1);
      reset_n = 1'b0;
      #1;
      check("rst_async_sda", sda_oe, 1'b0);
      check("rst_async_busy", busy, 1'b0);
      tick(3);
      reset_n = 1'b1;
      tick(3);
      sda_base  = sda_cnt;
      busy_base = busy_cnt;
      rx_base   = rx_q.size();
      write_byte(8'hA0, ack);
      check("post_rst_addr_ack", ack, 1'b1);
      write_byte(8'h77, ack);
      check("post_rst_data_ack", ack, 1'b1);
      send_stop();
      check("post_rst_sda_quiet", sda_cnt - sda_base, 0);
      check("post_rst_busy", busy_cnt - busy_base, 0);
      check("post_rst_rx", rx_q.size() - rx_base, 0);

      // Randomized transactions against the model
      for (int it = 0; it < 12; it++) begin
         logic [6:0] a;
         int         n;
         a = ($urandom_range(0, 1) == 0) ? OWN_ADDR : 7'($urandom_range(0, 127));
         n = $urandom_range(1, 3);
         if ($urandom_range(0, 1) == 1) begin
            for (int k = 0; k < 4; k++) wr_bytes[k] = 8'($urandom);
            run_write(a, n, 1'b1);
         end else begin
            run_read(a, n, 8'($urandom));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (slave) endpoint, the responder counterpart of the SoC I2C initiator. It lets an external I2C controller write bytes into the SoC and read bytes from it at a fixed 7-bit address, oversampling SCL/SDA on the core clock. It sits behind an MMIO wrapper or DMA glue that consumes received bytes and supplies transmit bytes through valid/ready-style strobes.

## Interface
- ADDR, 7'h50, 7-bit target address matched after START.
- clk  input  1  core clock; must be at least 16x the SCL frequency.
- reset_n  input  1  asynchronous, active-low reset.
- scl_in  input  1  SCL pad input (asynchronous).
- sda_in  input  1  SDA pad input (asynchronous).
- scl_oe  output  1  1 = pull SCL low (clock stretch); 0 = release.
- sda_oe  output  1  1 = pull SDA low; 0 = release.
- rx_data  output  8  last byte written by the controller.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- rx_first  output  1  qualifies rx_valid: first data byte after the address.
- tx_data  input  8  byte to return on controller reads.
- tx_valid  input  1  tx_data holds an unconsumed byte (level).
- tx_ready  output  1  one-cycle pulse when tx_data is consumed.
- tx_underrun  output  1  one-cycle pulse when a byte was needed and tx_valid was low.
- busy  output  1  high from own-address ACK until STOP, START, or NACKed read.

## Operation
- Inputs use 2-flop synchronizers plus a delay register. scl_rise, scl_fall, START (SDA falling while SCL high) and STOP (SDA rising while SCL high) are decoded from synchronized samples.
- Bit sampling happens on scl_rise. Drive changes happen on scl_fall. sda_oe is the inverse of the data bit.
- States and transitions:
  - IDLE: START -> ADDR, with bit_cnt=0.
  - ADDR: shift SDA on 8 rises into sr.
    - On the 8th rise, compare sr[7:1] with ADDR and latch rw=sr[0].
    - On the next fall: on a match, drive ACK and go to ADDR_ACK; otherwise go to IGNORE.
  - ADDR_ACK: on fall, if rw=0, release SDA and go to WR_DATA. If rw=1, fetch a byte (see below), drive bit7, and go to RD_DATA.
  - WR_DATA: shift 8 rises. On the 8th rise, update rx_data and pulse rx_valid. On the next fall, drive ACK and go to WR_ACK.
  - WR_ACK: on fall, release SDA and go to WR_DATA.
  - RD_DATA: on the falls after bit7, drive bits 6..0. On the fall ending bit0, release SDA and go to RD_ACK.
  - RD_ACK: on rise, sample SDA.
    - 0 (ACK): on the next fall, fetch a byte, drive bit7, and go to RD_DATA.
    - 1 (NACK): go to IGNORE.
  - IGNORE: release everything and wait.
- START in any state goes to ADDR (repeated start) and releases SDA. STOP in any state goes to IDLE and releases SDA and SCL. A STOP/START on the same cycle as a scl edge wins.
- Byte fetch: load the shift register from tx_data and pulse tx_ready if tx_valid is high. Otherwise load 8'hFF and pulse tx_underrun. The no-byte case changes when I2C_TARGET_STRETCH_EN is defined (see Configuration).
- The block always ACKs written data; there is no receive backpressure.
- Reset mid-transfer releases both lines immediately. The next transaction requires a fresh START.

## Timing
- Pin to internal edge event: 3 clk. SDA drive after an SCL fall: 4 clk after the pad edge.
- rx_valid: 4 clk after the pad rise of the 8th data bit. rx_first is high only on the first byte after ADDR_ACK.
- tx_ready/tx_underrun are asserted in the same cycle as the shift-register load.
- Reset values: scl_oe=0, sda_oe=0, rx_data=0, rx_valid=0, rx_first=0, tx_ready=0, tx_underrun=0, busy=0. The state resets to IDLE.

## Configuration
- I2C_TARGET_STRETCH_EN is the configuration macro.
- Defined: at a byte fetch with tx_valid low, assert scl_oe from the fetch fall until the cycle tx_valid is seen high.
  - In that cycle, load tx_data, pulse tx_ready, and drive bit7.
  - Release scl_oe one clk later.
  - tx_underrun never pulses.
  - A STOP or START during the stretch aborts it.
- Undefined: scl_oe is tied 0 and the underrun behavior (8'hFF) applies.

## Test plan
- Write to 0x50 (0xA0), bytes 0x5A, 0xC3, then STOP -> ACK on address and on both bytes. rx_valid pulses twice: 0x5A with rx_first=1, then 0xC3 with rx_first=0. busy falls at STOP.
- Address 0x51 write -> sda_oe stays 0 through the whole transaction; no rx_valid; busy=0.
- Read 0xA1, tx_valid=1, tx_data=0xA5, controller NACKs -> SDA shows 1010_0101; one tx_ready; state goes to IGNORE; busy=0.
- Write 0x11, then repeated START with read 0xA1 -> rx_valid for 0x11, then a read byte is returned from tx_data. No STOP is required between the two.
- Read with tx_valid low for 200 clk:
  - With I2C_TARGET_STRETCH_EN: scl_oe is held about 200 clk, the byte is correct, and there is no underrun.
  - Without: 0xFF is sent and tx_underrun pulses once.
- reset_n asserted mid-read while driving 0 -> sda_oe=0 asynchronously. After release, traffic is ignored until a new START.
